// File: rtl/beamscaler_pkg.sv
// Shared types, constants and word-packing helpers for the beamscaler scaler-RAM reader.
package beamscaler_pkg;

    localparam logic [7:0]  HDR_MAGIC = 8'hBE;
    localparam int unsigned SCAL_W    = 12;
    localparam int unsigned PRIM_LSB  = 0;
    localparam int unsigned SUB_LSB   = 16;

    typedef enum logic [1:0] {
        StIdle,
        StHeader,
        StSweep,
        StDrain
    } state_e;

    // One FIFO entry: payload, frame-end tag and {overrun, torn} status.
    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic [1:0]  user;
    } beat_t;

    function automatic logic [31:0] pack_header(input logic read_bank, input logic [15:0] frame_cnt);
        return {HDR_MAGIC, 7'b0, read_bank, frame_cnt};
    endfunction

    // Layout of a scaler RAM word; the reader passes these through untouched.
    function automatic logic [31:0] scal_word(input logic [SCAL_W-1:0] primary,
                                              input logic [SCAL_W-1:0] subthresh);
        logic [31:0] w;
        w = '0;
        w[PRIM_LSB +: SCAL_W] = primary;
        w[SUB_LSB  +: SCAL_W] = subthresh;
        return w;
    endfunction

endpackage

// File: rtl/beamscaler_reader_fifo.sv
// Small first-word-fall-through FIFO; count is exported for issue-credit accounting.
module beamscaler_reader_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 34
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_wr;
    logic             w_rd;

    assign w_wr    = i_push && (r_count < (AW+1)'(DEPTH));
    assign w_rd    = i_pop && (r_count != '0);
    assign o_data  = r_mem[r_rptr];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

    // Storage array; no reset needed since reads are gated by count.
    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_rd) r_rptr <= r_rptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/beamscaler_reader.sv
// Sweeps the readable scaler bank on each done pulse and frames it as one AXI4-Stream packet.
module beamscaler_reader
    import beamscaler_pkg::*;
#(
    parameter int unsigned NBEAMS     = 2,
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        done_i,
    input  logic        write_bank_i,
    output logic        scal_rd_o,
    output logic [7:0]  scal_adr_o,
    input  logic [31:0] scal_dat_i,
    output logic [31:0] m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast,
    output logic [1:0]  m_tuser,
    output logic        busy_o
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    state_e                r_state;
    logic                  r_busy;
    logic                  r_rd;
    logic                  r_rd_last;
    logic [7:0]            r_adr;
    logic [7:0]            r_addr;
    logic                  r_read_bank;
    logic [15:0]           r_frame_cnt;
    logic                  r_ovr;
    logic                  r_torn;
    logic [RD_LATENCY-1:0] r_vpipe;
    logic [RD_LATENCY-1:0] r_lpipe;

    beat_t                 w_in;
    beat_t                 w_out;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_empty;
    logic                  w_hdr_push;
    logic                  w_credit;
    logic                  w_ovr_now;
    logic                  w_torn_now;
    logic [CW-1:0]         w_count;
    logic [7:0]            w_used;

    assign w_pop      = !w_empty && m_tready;
    assign w_torn_now = r_torn || ((r_state != StIdle) && (write_bank_i == r_read_bank));
    assign w_ovr_now  = r_ovr || ((r_state != StIdle) && done_i);

    // Slots committed after this edge (occupancy plus every read not yet written) must fit,
    // counting the slot freed by a pop on the same edge so the sweep sustains 1 beat/cycle.
    always_comb begin
        w_used = 8'(w_count) + {7'b0, r_rd};
        for (int i = 0; i < RD_LATENCY; i++) begin
            w_used = w_used + {7'b0, r_vpipe[i]};
        end
        w_credit = (w_used + 8'd1) <= (8'(FIFO_DEPTH) + {7'b0, w_pop});
    end

    // FIFO write mux: header in HEADER, otherwise the RAM word arriving off the valid pipe.
    always_comb begin
        w_in       = '0;
        w_hdr_push = (r_state == StHeader) && w_credit;
        w_push     = w_hdr_push || r_vpipe[RD_LATENCY-1];
        if (w_hdr_push) begin
            w_in.data = pack_header(r_read_bank, r_frame_cnt);
        end else begin
            w_in.data = scal_dat_i;
            w_in.last = r_lpipe[RD_LATENCY-1];
            w_in.user = r_lpipe[RD_LATENCY-1] ? {w_ovr_now, w_torn_now} : 2'b00;
        end
    end

    // Frame FSM, read issue, capture pipe and sticky status flags.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_state     <= StIdle;
            r_busy      <= 1'b0;
            r_rd        <= 1'b0;
            r_rd_last   <= 1'b0;
            r_adr       <= '0;
            r_addr      <= '0;
            r_read_bank <= 1'b0;
            r_frame_cnt <= '0;
            r_ovr       <= 1'b0;
            r_torn      <= 1'b0;
            r_vpipe     <= '0;
            r_lpipe     <= '0;
        end else begin
            r_rd       <= 1'b0;
            r_rd_last  <= 1'b0;
            r_vpipe[0] <= r_rd;
            r_lpipe[0] <= r_rd_last;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_vpipe[i] <= r_vpipe[i-1];
                r_lpipe[i] <= r_lpipe[i-1];
            end
            r_torn <= w_torn_now;
            r_ovr  <= w_ovr_now;

            case (r_state)
                StIdle: begin
                    if (done_i) begin
                        r_read_bank <= ~write_bank_i;
                        r_busy      <= 1'b1;
                        r_state     <= StHeader;
                    end
                end
                StHeader: begin
                    if (w_credit) begin
                        r_addr  <= '0;
                        r_state <= StSweep;
                    end
                end
                StSweep: begin
                    if (w_credit) begin
                        r_rd      <= 1'b1;
                        r_adr     <= r_addr;
                        r_rd_last <= (r_addr == 8'(NBEAMS - 1));
                        if (r_addr == 8'(NBEAMS - 1)) begin
                            r_state <= StDrain;
                        end else begin
                            r_addr <= r_addr + 8'd1;
                        end
                    end
                end
                StDrain: begin
                    if (w_pop && w_out.last) begin
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                        r_ovr       <= 1'b0;
                        r_torn      <= 1'b0;
                        // A done on the closing beat is the next period, not an overrun.
                        if (done_i) begin
                            r_read_bank <= ~write_bank_i;
                            r_state     <= StHeader;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= StIdle;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    beamscaler_reader_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(beat_t))
    ) u_fifo (
        .i_clk   (wb_clk_i),
        .i_rst_n (wb_rst_n_i),
        .i_push  (w_push),
        .i_data  (w_in),
        .i_pop   (w_pop),
        .o_data  (w_out),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign m_tvalid   = !w_empty;
    assign m_tdata    = m_tvalid ? w_out.data : 32'd0;
    assign m_tlast    = m_tvalid && w_out.last;
    assign m_tuser    = m_tvalid ? w_out.user : 2'b00;
    assign scal_rd_o  = r_rd;
    assign scal_adr_o = r_adr;
    assign busy_o     = r_busy;

endmodule

// File: tb/tb_beamscaler_reader.sv
// Scoreboard bench: stimulus queues expected beats, a monitor pops them on each accepted beat.
module tb_beamscaler_reader;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_n_i;
    logic        done_i;
    logic        write_bank_i;
    logic        scal_rd_o;
    logic [7:0]  scal_adr_o;
    logic [31:0] scal_dat_i;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic [1:0]  m_tuser;
    logic        busy_o;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic [1:0]  user;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fails  = 0;
    int          rd_cnt   = 0;
    int          acc_cnt  = 0;
    logic        bp_en    = 1'b0;
    int          bp_idx   = 0;
    logic [15:0] bp_pat   = 16'b1001_0110_0011_1001;
    logic [15:0] frame_no = 16'd0;
    logic [31:0] ram_d1;

    beamscaler_reader #(
        .NBEAMS     (4),
        .RD_LATENCY (2),
        .FIFO_DEPTH (4)
    ) dut (
        .wb_clk_i     (wb_clk_i),
        .wb_rst_n_i   (wb_rst_n_i),
        .done_i       (done_i),
        .write_bank_i (write_bank_i),
        .scal_rd_o    (scal_rd_o),
        .scal_adr_o   (scal_adr_o),
        .scal_dat_i   (scal_dat_i),
        .m_tdata      (m_tdata),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .m_tlast      (m_tlast),
        .m_tuser      (m_tuser),
        .busy_o       (busy_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // RAM model: two-cycle read latency; poison value when no read was issued.
    always @(posedge wb_clk_i) begin
        ram_d1     <= scal_rd_o ? (32'h0ABC_0123 + {24'd0, scal_adr_o}) : 32'hDEAD_BEEF;
        scal_dat_i <= ram_d1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] hdr(input logic bank, input logic [15:0] cnt);
        return {8'hBE, 7'd0, bank, cnt};
    endfunction

    task automatic expect_frame(input logic bank, input logic [15:0] cnt, input logic [1:0] user);
        exp_q.push_back('{data: hdr(bank, cnt), last: 1'b0, user: 2'b00});
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back('{data: 32'h0ABC_0123 + 32'(k), last: (k == 3),
                              user: (k == 3) ? user : 2'b00});
        end
        rd_cnt  = 0;
        acc_cnt = 0;
    endtask

    task automatic pulse_done();
        @(posedge wb_clk_i); #1 done_i = 1'b1;
        @(posedge wb_clk_i); #1 done_i = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (n < 100 && !(exp_q.size() == 0 && !busy_o)) begin
            @(negedge wb_clk_i);
            n++;
        end
        check(name, {exp_q.size() == 0, busy_o}, 2'b10);
        frame_no = frame_no + 16'd1;
    endtask

    // Ready driver: constant high, or a fixed pseudo-random pattern when backpressure is on.
    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge wb_clk_i);
            #1;
            if (bp_en) begin
                m_tready = bp_pat[bp_idx];
                bp_idx   = (bp_idx + 1) % 16;
            end else begin
                m_tready = 1'b1;
            end
        end
    end

    // Monitor: read-issue ordering/credit, then scoreboard compare on each accepted beat.
    initial begin
        forever begin
            @(negedge wb_clk_i);
            if (wb_rst_n_i) begin
                if (scal_rd_o) begin
                    check("rd_addr", 64'(scal_adr_o), 64'(rd_cnt));
                    check("rd_credit", 64'((1 + rd_cnt - acc_cnt) < 4), 64'd1);
                    rd_cnt++;
                end
                if (m_tvalid && m_tready) begin
                    acc_cnt++;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fails++;
                        $display("FAIL beat: unexpected beat %h last=%b user=%b, expected none",
                                 m_tdata, m_tlast, m_tuser);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("beat", {m_tdata, m_tlast, m_tuser}, mon_e);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1);
    end

    initial begin
        wb_rst_n_i   = 1'b0;
        done_i       = 1'b0;
        write_bank_i = 1'b0;
        #2;
        check("reset_outputs", {scal_rd_o, scal_adr_o, m_tvalid, m_tlast, m_tuser, busy_o}, '0);
        // done during reset is ignored
        #3 done_i = 1'b1;
        @(posedge wb_clk_i); #1 done_i = 1'b0;
        @(negedge wb_clk_i); wb_rst_n_i = 1'b1;
        repeat (3) @(negedge wb_clk_i);
        check("done_in_reset_ignored", {busy_o, m_tvalid}, 2'b00);

        // Frame 1 with latency checks: header tvalid two cycles after done.
        expect_frame(1'b1, frame_no, 2'b00);
        @(posedge wb_clk_i); #1 done_i = 1'b1;
        @(posedge wb_clk_i); #1 done_i = 1'b0;
        #3 check("busy_before_header", {busy_o, m_tvalid}, 2'b10);
        @(posedge wb_clk_i); #4 check("header_valid", 64'(m_tvalid), 64'd1);
        wait_idle("frame1_done");
        @(negedge wb_clk_i);
        check("empty_no_valid", {m_tvalid, m_tlast, m_tuser}, '0);

        // Frame 2: counter advances.
        expect_frame(1'b1, frame_no, 2'b00);
        pulse_done();
        wait_idle("frame2_done");

        // Backpressure frame.
        bp_en = 1'b1;
        expect_frame(1'b1, frame_no, 2'b00);
        pulse_done();
        wait_idle("bp_frame_done");
        bp_en = 1'b0;
        repeat (2) @(posedge wb_clk_i);

        // Overrun: second done three cycles into the frame.
        expect_frame(1'b1, frame_no, 2'b10);
        pulse_done();
        repeat (2) @(posedge wb_clk_i);
        #1 done_i = 1'b1;
        @(posedge wb_clk_i); #1 done_i = 1'b0;
        wait_idle("overrun_frame_done");
        repeat (4) @(negedge wb_clk_i);
        check("no_restart_after_overrun", {m_tvalid, busy_o}, 2'b00);
        expect_frame(1'b1, frame_no, 2'b00);
        pulse_done();
        wait_idle("post_overrun_frame_done");

        // Torn: writer flips bank mid-sweep.
        expect_frame(1'b1, frame_no, 2'b01);
        pulse_done();
        repeat (2) @(posedge wb_clk_i);
        #1 write_bank_i = 1'b1;
        wait_idle("torn_frame_done");
        write_bank_i = 1'b0;
        repeat (2) @(posedge wb_clk_i);

        // Frame counter wrap via preset.
        @(negedge wb_clk_i);
        force dut.r_frame_cnt = 16'hFFFF;
        @(negedge wb_clk_i);
        release dut.r_frame_cnt;
        frame_no = 16'hFFFF;
        expect_frame(1'b1, frame_no, 2'b00);
        pulse_done();
        wait_idle("wrap_ffff_done");
        expect_frame(1'b1, frame_no, 2'b00);
        pulse_done();
        wait_idle("wrap_0000_done");

        // Asynchronous reset during the sweep.
        expect_frame(1'b1, frame_no, 2'b00);
        pulse_done();
        repeat (2) @(posedge wb_clk_i);
        #3 wb_rst_n_i = 1'b0;
        #1 check("async_reset_outputs",
                 {scal_rd_o, scal_adr_o, m_tvalid, m_tlast, m_tuser, busy_o}, '0);
        exp_q.delete();
        rd_cnt  = 0;
        acc_cnt = 0;
        repeat (2) @(negedge wb_clk_i);
        wb_rst_n_i = 1'b1;
        repeat (2) @(negedge wb_clk_i);
        check("post_reset_idle", {m_tvalid, busy_o}, 2'b00);
        frame_no = 16'd0;
        expect_frame(1'b1, frame_no, 2'b00);
        pulse_done();
        wait_idle("post_reset_frame_done");

        repeat (3) @(posedge wb_clk_i);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
